apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_slave_regfile.sv | 61 ++++++
 rtl/apb_slave_regs.sv | 143 ++++++++++++++
 tb/tb_apb_slave_regs.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB register slave
//
// Purpose: state encoding for the transfer FSM, the default contents of the
// read-only ID register, and the constants that split a byte address into
// alignment bits and a word index. Imported by apb_slave_regs and
// apb_slave_regfile.
// Ports: none (package).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_DEFAULT_ID = 32'hA9B4_0001;

  // Byte address layout: [1:0] must be zero, [7:2] select the 32-bit word.
  localparam int         APB_IDX_LSB  = 2;
  localparam int         APB_IDX_MSB  = 7;
  localparam int         APB_IDX_W    = APB_IDX_MSB - APB_IDX_LSB + 1;
  localparam logic [1:0] APB_ALIGN_OK = 2'b00;

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - byte-strobed register array with read mux
//
// Purpose: holds registers 1..NUM_REGS-1 (byte-lane writable) and returns the
// constant ID_VALUE for register 0. Reads of an index with no register
// return 0. All decode/error qualification happens in the parent.
// Ports:
//   PCLK, PRESETn   clock, asynchronous active-low reset (clears registers)
//   wr_en           commit a write this cycle
//   wr_idx/wr_data/wr_strb  word index, data and byte-lane enables
//   rd_idx          word index for the combinational read mux
//   rd_data         selected register contents
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = APB_DEFAULT_ID
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 wr_en,
  input  logic [APB_IDX_W-1:0] wr_idx,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_strb,
  input  logic [APB_IDX_W-1:0] rd_idx,
  output logic [31:0]          rd_data
);

  // Register 0 is a constant, so storage starts at index 1.
  logic [31:0] regs [1:NUM_REGS-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_idx == APB_IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
              regs[i][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx == '0) begin
      rd_data = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_idx == APB_IDX_W'(i)) begin
        rd_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB slave with NUM_REGS 32-bit registers and wait states
//
// Purpose: APB transfer FSM (IDLE/WAIT/RESP), address decode and error
// detection in front of apb_slave_regfile. Request fields are captured on the
// setup edge; later changes during the access phase are ignored.
// Optional feature: define APB_SLAVE_PROT_CHECK_EN to reject unprivileged
// (PPROT[0]=0) writes to the upper half of the register space.
// Ports:
//   PCLK, PRESETn       clock, asynchronous active-low reset
//   PSEL, PENABLE       APB select / access phase
//   PWRITE, PADDR, PWDATA, PSTRB, PPROT  request fields
//   PRDATA, PREADY, PSLVERR             response (all 0 outside a completing cycle)
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = APB_DEFAULT_ID
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [APB_IDX_W:0] REG_LIMIT = (APB_IDX_W+1)'(NUM_REGS);
  // Only meaningful when WAIT_CYCLES > 0; WAIT is unreachable otherwise.
  localparam logic [3:0]         WAIT_LAST = 4'(WAIT_CYCLES - 1);

  apb_state_e           state;
  logic [3:0]           wait_cnt;
  logic                 pwrite_q;
  logic [APB_IDX_W-1:0] idx_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic                 err_q;

  logic                 setup;
  logic                 setup_err;
  logic [APB_IDX_W-1:0] setup_idx;
  logic [31:0]          rd_data;
  logic                 wr_en;
  logic                 unused_bits;

  assign setup     = PSEL && !PENABLE;
  assign setup_idx = PADDR[APB_IDX_MSB:APB_IDX_LSB];

  // Upper address bits take no part in decode.
  assign unused_bits = ^{PADDR[31:APB_IDX_MSB+1], PPROT};

  // Error is resolved from the live bus at the setup edge and held with the
  // captured request, so access-phase bus changes cannot affect it.
  always_comb begin
    setup_err = 1'b0;
    if (PADDR[APB_IDX_LSB-1:0] != APB_ALIGN_OK) begin
      setup_err = 1'b1;
    end
    if ({1'b0, setup_idx} >= REG_LIMIT) begin
      setup_err = 1'b1;
    end
    if (PWRITE && (setup_idx == '0)) begin
      setup_err = 1'b1;
    end
`ifdef APB_SLAVE_PROT_CHECK_EN
    if (PWRITE && !PPROT[0] && ({1'b0, setup_idx} >= (APB_IDX_W+1)'(NUM_REGS / 2))) begin
      setup_err = 1'b1;
    end
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (setup) begin
            pwrite_q <= PWRITE;
            idx_q    <= setup_idx;
            wdata_q  <= PWDATA;
            strb_q   <= PSTRB;
            err_q    <= setup_err;
            state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Response qualifies on live PSEL/PENABLE so a dropped select never completes.
  assign PREADY  = (state == RESP) && PSEL && PENABLE;
  assign PSLVERR = PREADY && err_q;
  assign wr_en   = PREADY && pwrite_q && !err_q;
  assign PRDATA  = (PREADY && !pwrite_q && !err_q) ? rd_data : 32'h0;

  apb_slave_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - self-checking bench for apb_slave_regs (zero-wait and 3-wait instances)
module tb_apb_slave_regs;

  localparam int          NREGS = 16;
  localparam int          WAITS0 = 0;
  localparam int          WAITS1 = 3;
  localparam logic [31:0] ID = 32'hA9B4_0001;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb_slave_regs #(.NUM_REGS(NREGS), .WAIT_CYCLES(WAITS0), .ID_VALUE(ID)) dut0 (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PPROT(pprot[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_regs #(.NUM_REGS(NREGS), .WAIT_CYCLES(WAITS1), .ID_VALUE(ID)) dut1 (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PPROT(pprot[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] mdl [2][NREGS];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input int d);
    return ((d == 0) ? WAITS0 : WAITS1) + 1;
  endfunction

  function automatic bit m_err(input bit wr, input logic [31:0] addr, input logic [2:0] prot);
    int idx;
    bit e;
    idx = int'(addr[7:2]);
    e = (addr[1:0] != 2'b00) || (idx >= NREGS) || (wr && idx == 0);
`ifdef APB_SLAVE_PROT_CHECK_EN
    if (wr && !prot[0] && idx >= NREGS / 2) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic void m_write(input int d, input int idx, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREGS; i++) mdl[d][i] = 32'h0;
    end
  endfunction

  // One APB transfer; access-phase bus fields are scrambled to show they are ignored.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er, output int lat);
    bit done;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
    @(posedge pclk); #1;
    penable[d] = 1'b1; pwrite[d] = ~wr;
    paddr[d] = $urandom; pwdata[d] = $urandom;
    pstrb[d] = 4'($urandom); pprot[d] = 3'($urandom);
    lat = 1; done = 1'b0; rd = '0; er = 1'b0;
    while (!done && lat <= 20) begin
      @(negedge pclk);
      if (pready[d] === 1'b1) begin
        done = 1'b1; rd = prdata[d]; er = pslverr[d];
      end else begin
        @(posedge pclk); #1;
        lat++;
      end
    end
    if (!done) lat = -1;
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic run(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] prot, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          e_err;
    logic [31:0] e_rd;
    int          idx;
    idx   = int'(addr[7:2]);
    e_err = m_err(wr, addr, prot);
    e_rd  = 32'h0;
    if (!wr && !e_err) e_rd = (idx == 0) ? ID : mdl[d][idx];
    xfer(d, wr, addr, data, strb, prot, rd, er, lat);
    check({tag, " latency"}, lat, exp_lat(d));
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, e_err});
    check({tag, " prdata"}, rd, e_rd);
    if (wr && !e_err) m_write(d, idx, data, strb);
    last_rd = rd;
  endtask

  task automatic check_idle(input string tag);
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s pready%0d", tag, d), {31'b0, pready[d]}, 32'h0);
      check($sformatf("%s pslverr%0d", tag, d), {31'b0, pslverr[d]}, 32'h0);
      check($sformatf("%s prdata%0d", tag, d), prdata[d], 32'h0);
    end
  endtask

  initial begin
    bit saw;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    m_reset();
    last_rd = '0;
    rst_n = 1'b0;

    // Reset state, sampled before any clock edge
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset pready%0d", d), {31'b0, pready[d]}, 32'h0);
      check($sformatf("reset pslverr%0d", d), {31'b0, pslverr[d]}, 32'h0);
      check($sformatf("reset prdata%0d", d), prdata[d], 32'h0);
    end
    repeat (2) @(posedge pclk);
    #1 rst_n = 1'b1;

    // Zero-wait write then read
    run(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, "w04");
    run(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, "r04");
    check("r04 literal", last_rd, 32'hDEADBEEF);

    // Partial strobe
    run(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'b001, "w08 full");
    run(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b001, "w08 strb0101");
    run(0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, "r08");
    check("r08 literal", last_rd, 32'h11BB33DD);
    run(0, 1'b1, 32'h08, 32'h99999999, 4'h0, 3'b001, "w08 strb0");
    run(0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, "r08 after strb0");

    // Wait states: ID register through the 3-wait instance
    run(1, 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, "r00 wait3");
    check("r00 wait3 literal", last_rd, 32'hA9B40001);

    // Error cases
    run(0, 1'b1, 32'h00, 32'h12345678, 4'hF, 3'b001, "err w00");
    run(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b001, "err r40");
    run(0, 1'b0, 32'h06, 32'h0, 4'hF, 3'b001, "err r06");
    run(0, 1'b1, 32'h05, 32'h55555555, 4'hF, 3'b001, "err w05");
    run(0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, "r00 after err");
    run(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, "r04 after err");
    check_idle("idle1");

    // Protection check on index 8
    run(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, "w20 prot000");
    run(0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, "r20 a");
    run(0, 1'b1, 32'h20, 32'h0BADC0DE, 4'hF, 3'b001, "w20 prot001");
    run(0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, "r20 b");

    // Abort: PSEL drops in WAIT, then returns without a setup phase
    run(1, 1'b1, 32'h14, 32'h13572468, 4'hF, 3'b001, "w14 pre");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h14; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    @(posedge pclk); #1 penable[1] = 1'b1;
    @(posedge pclk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1 psel[1] = 1'b1; penable[1] = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge pclk);
      if (pready[1] !== 1'b0) saw = 1'b1;
    end
    check("abort no pready", {31'b0, saw}, 32'h0);
    @(posedge pclk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    run(1, 1'b0, 32'h14, 32'h0, 4'hF, 3'b001, "r14 after abort");
    check("r14 after abort literal", last_rd, 32'h13572468);

    // Randomized transfers against the model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        logic [31:0] hi;
        logic [31:0] dat;
        logic [5:0]  ix;
        logic [1:0]  of;
        hi  = $urandom;
        dat = $urandom;
        ix  = 6'($urandom_range(0, 19));
        of  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        run(d, 1'($urandom), {hi[31:8], ix, of}, dat, 4'($urandom), 3'($urandom),
            $sformatf("rand%0d_%0d", d, n));
      end
    end
    check_idle("idle2");

    // Reset pulsed while a read is completing
    run(0, 1'b1, 32'h04, 32'h600DF00D, 4'hF, 3'b001, "w04 pre-rst");
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0;
    paddr[0] = 32'h04; pwdata[0] = '0; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    @(posedge pclk); #1 penable[0] = 1'b1;
    @(negedge pclk);
    check("pre-rst pready", {31'b0, pready[0]}, 32'h1);
    check("pre-rst prdata", prdata[0], 32'h600DF00D);
    #1 rst_n = 1'b0;
    #1;
    check("rst pready", {31'b0, pready[0]}, 32'h0);
    check("rst pslverr", {31'b0, pslverr[0]}, 32'h0);
    check("rst prdata", prdata[0], 32'h0);
    @(posedge pclk); #1 rst_n = 1'b1;
    m_reset();
    saw = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready[0] !== 1'b0) saw = 1'b1;
    end
    check("post-rst no pready", {31'b0, saw}, 32'h0);
    @(posedge pclk); #1 psel[0] = 1'b0; penable[0] = 1'b0;
    run(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, "r04 post-rst");
    check("r04 post-rst literal", last_rd, 32'h0);
    run(1, 1'b0, 32'h14, 32'h0, 4'hF, 3'b001, "r14 post-rst");
    run(0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, "r00 post-rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
